// File: rtl/pipeline_ctrl_unit_pkg.sv
// pipeline_ctrl_unit_pkg: shared FSM encodings and register-number width
package pipeline_ctrl_unit_pkg;
  localparam int REG_W = 4;
  typedef enum logic [1:0] {S_RUN = 2'd0, S_MEM_WAIT = 2'd1, S_ERROR = 2'd2} state_t;
endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// pipeline_ctrl_unit_if: pipeline status in, stage-register freeze/flush controls out
interface pipeline_ctrl_unit_if
  import pipeline_ctrl_unit_pkg::*;
#(parameter int CNT_W = 16);
  logic id_valid, two_src, fwd_en, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, sram_ready, branch_taken;
  logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
  logic freeze_if, flush_if, flush_id, freeze_all, mem_start, err_timeout;
  logic [CNT_W-1:0] bubble_cnt;
  modport master (
    output id_valid, two_src, fwd_en, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, sram_ready, branch_taken,
           src1, src2, exe_dest, mem_dest,
    input  freeze_if, flush_if, flush_id, freeze_all, mem_start, err_timeout, bubble_cnt
  );
  modport slave (
    input  id_valid, two_src, fwd_en, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, sram_ready, branch_taken,
           src1, src2, exe_dest, mem_dest,
    output freeze_if, flush_if, flush_id, freeze_all, mem_start, err_timeout, bubble_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_unit_hazard.sv
// pipeline_ctrl_unit_hazard: combinational RAW / load-use hazard detection for the ID stage
module pipeline_ctrl_unit_hazard
  import pipeline_ctrl_unit_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);
  logic exe_hit, mem_hit;
  assign exe_hit = exe_wb_en & (src1 == exe_dest | two_src & src2 == exe_dest);
  assign mem_hit = mem_wb_en & (src1 == mem_dest | two_src & src2 == mem_dest);
  // with forwarding only a load in EXE cannot be bypassed in time
  assign hazard  = id_valid & (fwd_en ? exe_hit & exe_mem_r_en : exe_hit | mem_hit);
endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: SRAM-wait FSM, hazard bubble counter and freeze/flush priority mux
module pipeline_ctrl_unit
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_unit_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);
  state_t state, state_n;
  logic [WW-1:0] wait_cnt;
  logic [CNT_W-1:0] bub;
  logic hazard, fa, br, bubble;
  pipeline_ctrl_unit_hazard u_hazard (
    .id_valid     (bus.id_valid),
    .src1         (bus.src1),
    .src2         (bus.src2),
    .two_src      (bus.two_src),
    .fwd_en       (bus.fwd_en),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard       (hazard)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      bub      <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= state == S_MEM_WAIT ? wait_cnt + 1'b1 : '0;
      if (bubble && !(&bub)) bub <= bub + 1'b1;
    end
  end
  // sram_ready takes precedence over the timeout in the same cycle
  always_comb begin
    state_n = state;
    if (state == S_RUN && bus.mem_req) state_n = S_MEM_WAIT;
    else if (state == S_MEM_WAIT) state_n = bus.sram_ready ? S_RUN : wait_cnt == LAST ? S_ERROR : S_MEM_WAIT;
  end
  always_comb begin
    fa              = !rst && (state == S_RUN ? bus.mem_req : state == S_MEM_WAIT ? !bus.sram_ready : 1'b1);
    br              = !rst && !fa && bus.branch_taken;
    bubble          = !rst && !fa && !bus.branch_taken && hazard;
    bus.freeze_all  = fa;
    bus.mem_start   = !rst && state == S_RUN && bus.mem_req;
    bus.flush_if    = br;
    bus.flush_id    = br | bubble;
    bus.freeze_if   = bubble;
    bus.err_timeout = !rst && state == S_ERROR;
    bus.bubble_cnt  = bub;
  end
endmodule
